tile_pair_ctrl: RTL and testbench

Game controller for the memory-match board: turns left-button presses into per-tile face-up/face-down commands, compares each pair of uncovered tiles, and either locks them as matched or re-covers them after a display delay. It sits between the mouse interface (MouseLeft, xpos, ypos) and the per-tile image multiplexers. Each tile's image mux shows the picture when its `revealed` bit is 1 and the cover/background when it is 0. Unlike the per-tile click-toggle logic, this block owns the whole board and issues the cover commands itself.

---
 rtl/tile_pair_ctrl.sv | 167 ++++++++++++++++
 tb/tb_tile_pair_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/tile_pair_ctrl.sv
// Memory-match board controller: turns left-button presses into per-tile reveal commands,
// compares uncovered pairs, locks matches and re-covers mismatches after a hold delay.
module tile_pair_ctrl #(
    parameter int unsigned  COLS        = 4,
    parameter int unsigned  ROWS        = 2,
    parameter int unsigned  X0          = 100,
    parameter int unsigned  Y0          = 100,
    parameter int unsigned  TILE_W      = 100,
    parameter int unsigned  TILE_H      = 100,
    parameter int unsigned  GAP         = 20,
    parameter int unsigned  HOLD_CYCLES = 16,
    localparam int unsigned N           = COLS * ROWS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          MouseLeft,
    input  logic [11:0]   xpos,
    input  logic [11:0]   ypos,
    output logic [N-1:0]  revealed,
    output logic [N-1:0]  matched,
    output logic [7:0]    moves,
    output logic          busy,
    output logic          game_done
);

    localparam int unsigned IW = (N > 2) ? $clog2(N) : 1;
    localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, ONE, CMP, HOLD, DONE} state_t;

    state_t          state, state_n;
    logic            armed;
    logic            ml_prev;
    logic            press_q;
    logic [11:0]     x_q, y_q;
    logic            hit_v_q;
    logic [IW-1:0]   hit_idx_q;
    logic [IW-1:0]   a, a_n, b, b_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [N-1:0]    rev_n, mat_n;
    logic [7:0]      moves_n;
    logic            locked;
    logic            hit_c;
    logic [IW-1:0]   hit_idx_c;
    logic            valid;
    logic [IW-1:0]   pair_a;

    // Presses seen while the FSM is not accepting clicks are dropped at every pipeline stage.
    assign locked = (state == CMP) || (state == HOLD) || (state == DONE);

    // Inclusive-edge hit test on the captured coordinates; gap pixels hit nothing.
    always_comb begin
        logic        col_v, row_v;
        int unsigned col_i, row_i;
        col_v = 1'b0;
        row_v = 1'b0;
        col_i = 0;
        row_i = 0;
        for (int unsigned c = 0; c < COLS; c++) begin
            if (32'(x_q) >= X0 + c * (TILE_W + GAP) &&
                32'(x_q) <= X0 + c * (TILE_W + GAP) + TILE_W) begin
                col_v = 1'b1;
                col_i = c;
            end
        end
        for (int unsigned r = 0; r < ROWS; r++) begin
            if (32'(y_q) >= Y0 + r * (TILE_H + GAP) &&
                32'(y_q) <= Y0 + r * (TILE_H + GAP) + TILE_H) begin
                row_v = 1'b1;
                row_i = r;
            end
        end
        hit_c     = col_v && row_v;
        hit_idx_c = IW'(row_i * COLS + col_i);
    end

    assign valid  = hit_v_q && !revealed[hit_idx_q] && !matched[hit_idx_q];
    assign pair_a = IW'((32'(a) + N / 2) % N);

    always_comb begin
        state_n = state;
        rev_n   = revealed;
        mat_n   = matched;
        moves_n = moves;
        a_n     = a;
        b_n     = b;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (valid) begin
                    rev_n[hit_idx_q] = 1'b1;
                    a_n              = hit_idx_q;
                    state_n          = ONE;
                end
            end
            ONE: begin
                if (valid) begin
                    rev_n[hit_idx_q] = 1'b1;
                    b_n              = hit_idx_q;
                    state_n          = CMP;
                end
            end
            CMP: begin
                moves_n = (moves == 8'hFF) ? moves : moves + 8'd1;
                if (b == pair_a) begin
                    mat_n[a] = 1'b1;
                    mat_n[b] = 1'b1;
                    state_n  = (&mat_n) ? DONE : IDLE;
                end else begin
                    cnt_n   = CW'(HOLD_CYCLES - 1);
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    rev_n[a] = 1'b0;
                    rev_n[b] = 1'b0;
                    state_n  = IDLE;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            DONE: ;
            default: state_n = IDLE;
        endcase
    end

    // armed keeps a button held through reset release from counting as a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            armed     <= 1'b0;
            ml_prev   <= 1'b0;
            press_q   <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            hit_v_q   <= 1'b0;
            hit_idx_q <= '0;
            a         <= '0;
            b         <= '0;
            cnt       <= '0;
            revealed  <= '0;
            matched   <= '0;
            moves     <= '0;
            busy      <= 1'b0;
            game_done <= 1'b0;
        end else begin
            armed     <= 1'b1;
            ml_prev   <= MouseLeft;
            press_q   <= MouseLeft && !ml_prev && armed && !locked;
            x_q       <= xpos;
            y_q       <= ypos;
            hit_v_q   <= press_q && hit_c && !locked;
            hit_idx_q <= hit_idx_c;
            state     <= state_n;
            a         <= a_n;
            b         <= b_n;
            cnt       <= cnt_n;
            revealed  <= rev_n;
            matched   <= mat_n;
            moves     <= moves_n;
            busy      <= (state_n == CMP) || (state_n == HOLD);
            game_done <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_tile_pair_ctrl.sv
// Scoreboard bench for tile_pair_ctrl: expectations are queued as stimulus is applied and
// compared against the DUT outputs once the pipeline has produced them.
module tb_tile_pair_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        MouseLeft;
    logic [11:0] xpos, ypos;
    logic [7:0]  revealed, matched, moves;
    logic        busy, game_done;

    int checks = 0;
    int errors = 0;

    string       tag_q[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    tile_pair_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .MouseLeft (MouseLeft),
        .xpos      (xpos),
        .ypos      (ypos),
        .revealed  (revealed),
        .matched   (matched),
        .moves     (moves),
        .busy      (busy),
        .game_done (game_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observe(input string t);
        case (t)
            "rev":   return 32'(revealed);
            "mat":   return 32'(matched);
            "moves": return 32'(moves);
            "busy":  return 32'(busy);
            "done":  return 32'(game_done);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_out(input string t, input logic [31:0] v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    task automatic drain(input string label);
        string       t;
        logic [31:0] v;
        while (tag_q.size() > 0) begin
            t = tag_q.pop_front();
            v = exp_q.pop_front();
            check({label, ".", t}, observe(t), v);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One low sample, then a 3-cycle press; returns just after the FSM edge (E2).
    task automatic press(input int x, input int y);
        step(1);
        xpos      = 12'(x);
        ypos      = 12'(y);
        MouseLeft = 1'b1;
        step(3);
        MouseLeft = 1'b0;
    endtask

    task automatic press_tile(input int i);
        press(150 + 120 * (i % 4), 150 + 120 * (i / 4));
    endtask

    task automatic do_reset;
        rst       = 1'b1;
        MouseLeft = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; MouseLeft = 1'b0; xpos = '0; ypos = '0;

        // Button held through reset release must not register.
        MouseLeft = 1'b1; xpos = 12'd150; ypos = 12'd150;
        step(3);
        rst = 1'b0;
        step(10);
        expect_out("rev", 0); expect_out("mat", 0); expect_out("moves", 0);
        expect_out("busy", 0); expect_out("done", 0);
        drain("reset_held");
        MouseLeft = 1'b0;
        step(3);
        expect_out("rev", 0);
        drain("after_release");

        // Reveal latency: high two cycles after the rise is first sampled.
        do_reset();
        step(1);
        xpos = 12'd150; ypos = 12'd150; MouseLeft = 1'b1;
        step(2);
        expect_out("rev", 0);
        drain("lat_e1");
        step(1);
        expect_out("rev", 32'h01);
        drain("lat_e2");
        MouseLeft = 1'b0;
        press(150, 150);
        expect_out("rev", 32'h01); expect_out("busy", 0);
        drain("repress");

        // Matching pair 0/4.
        do_reset();
        press_tile(0);
        press_tile(4);
        expect_out("busy", 1); expect_out("rev", 32'h11); expect_out("mat", 0);
        drain("match_cmp");
        step(1);
        expect_out("busy", 0); expect_out("mat", 32'h11); expect_out("rev", 32'h11);
        expect_out("moves", 1); expect_out("done", 0);
        drain("match_post");

        // Mismatch 0/1 with an ignored click during HOLD.
        do_reset();
        press_tile(0);
        press_tile(1);
        expect_out("busy", 1); expect_out("rev", 32'h03);
        drain("mis_cmp");
        n = 1;
        press_tile(4);
        expect_out("busy", 1); expect_out("rev", 32'h03);
        drain("mis_hold_click");
        n += 4;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (busy) n++;
            else break;
        end
        check("mis_busy_cycles", 32'(n), 32'd17);
        step(5);
        expect_out("rev", 0); expect_out("mat", 0); expect_out("moves", 1);
        expect_out("busy", 0);
        drain("mis_post");

        // Boundaries: inclusive corner, gap, left of board.
        do_reset();
        press(200, 100);
        expect_out("rev", 32'h01);
        drain("corner");
        press(210, 150);
        expect_out("rev", 32'h01); expect_out("busy", 0);
        drain("gap");
        press(99, 150);
        expect_out("rev", 32'h01); expect_out("busy", 0);
        drain("left_edge");

        // Full game, then ignored clicks, then reset.
        do_reset();
        for (int p = 0; p < 4; p++) begin
            press_tile(p);
            press_tile(p + 4);
        end
        step(1);
        expect_out("done", 1); expect_out("moves", 4); expect_out("mat", 32'hFF);
        expect_out("rev", 32'hFF); expect_out("busy", 0);
        drain("game_done");
        press_tile(0);
        step(2);
        expect_out("done", 1); expect_out("moves", 4); expect_out("busy", 0);
        drain("done_click");
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        expect_out("rev", 0); expect_out("mat", 0); expect_out("moves", 0);
        expect_out("busy", 0); expect_out("done", 0);
        drain("final_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
